// File: rtl/setup_rand_arbiter.sv
// -----------------------------------------------------------------------------
// setup_rand_arbiter
//
// This block shares the single random_32 generator among the setup-phase
// placers: 0 = nests, 1 = ants, 2 = patches. It works in the following order:
//   1. It strobes LD_seed for SEED_CYCLES cycles.
//   2. It waits for the first nonzero word and throws that word away.
//   3. It then buffers one fresh word at a time.
//   4. It hands each buffered word to exactly one requester, chosen by
//      round-robin arbitration.
//
// Handshake: a requester raises req[i] and holds it until it sees gnt[i].
// gnt[i] is registered and lasts one cycle, and gnt_data carries the word in
// that same cycle. The requester drops req[i] in the cycle after gnt[i].
// Because req[i] is still high while gnt[i] is visible, the arbiter masks the
// index it has just granted for that one cycle.
//
// Optional feature: define RAND_GRANT_CNT_EN to add grant_cnt. It holds
// per-requester saturating grant counters, which clear on reset and on every
// seed request.
//
// Ports:
//   setup_clk   in   setup clock
//   RESET_SIM   in   asynchronous, active-high reset
//   seed_req    in   one-cycle pulse; (re)starts the seed sequence
//   LD_seed     out  seed load strobe to random_32
//   rand_value  in   random_32 output word
//   rand_valid  in   one-cycle pulse: rand_value holds a new word
//   req         in   per-requester request levels
//   gnt         out  one-hot grant, one cycle wide
//   gnt_data    out  word delivered with gnt (0 when no grant)
//   gnt_id      out  index of the granted requester (0 when no grant)
//   ready       out  high while arbitration is running
//   zero_err    out  sticky: a zero word arrived while running
//   grant_cnt   out  per-requester grant counts (RAND_GRANT_CNT_EN only)
//   state_dbg   out  current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module setup_rand_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int REQ_bits    = 2,
  parameter int DATA_W      = 32,
  parameter int SEED_CYCLES = 4
) (
  input  logic                      setup_clk,
  input  logic                      RESET_SIM,
  input  logic                      seed_req,
  output logic                      LD_seed,
  input  logic [DATA_W-1:0]         rand_value,
  input  logic                      rand_valid,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         gnt_data,
  output logic [REQ_bits-1:0]       gnt_id,
  output logic                      ready,
  output logic                      zero_err,
`ifdef RAND_GRANT_CNT_EN
  output logic [NUM_REQ-1:0][15:0]  grant_cnt,
`endif
  output logic [1:0]                state_dbg
);

  localparam int CNT_W = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SEED_CYCLES - 1);
  localparam logic [REQ_bits-1:0] ID_LAST  = REQ_bits'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEED, WAIT_NZ, RUN} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DATA_W-1:0]     buf_q;
  logic                  buf_v;
  logic [REQ_bits-1:0]   last;

  logic                  rand_nz;
  logic [NUM_REQ-1:0]    req_eff;
  logic                  hi_found, lo_found;
  logic [REQ_bits-1:0]   hi_idx, lo_idx, win_idx;
  logic                  grant_now, refill;

  assign state_dbg = state;
  assign rand_nz   = |rand_value;
  // Hide the index granted last cycle: its req is still high while gnt shows.
  assign req_eff   = req & ~gnt;

  // Next-state logic. A seed request overrides every state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: ;
      SEED: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_nxt = WAIT_NZ;
          cnt_nxt   = '0;
        end
      end
      WAIT_NZ: if (rand_valid && rand_nz) state_nxt = RUN;
      RUN: ;
      default: state_nxt = IDLE;
    endcase
    if (seed_req) begin
      state_nxt = SEED;
      cnt_nxt   = '0;
    end
  end

  // Round-robin search. Requesters above `last` win first, lowest index
  // first; otherwise the search wraps to the lowest requesting index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_eff[i]) begin
        lo_found = 1'b1;
        lo_idx   = REQ_bits'(i);
        if (REQ_bits'(i) > last) begin
          hi_found = 1'b1;
          hi_idx   = REQ_bits'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  assign grant_now = (state == RUN) && !seed_req && buf_v && lo_found;
  // Capture a new word when the buffer is empty, or when its word leaves
  // in this same cycle.
  assign refill    = (state == RUN) && !seed_req && rand_valid && rand_nz &&
                     (!buf_v || grant_now);

  always_ff @(posedge setup_clk or posedge RESET_SIM) begin
    if (RESET_SIM) begin
      state    <= IDLE;
      cnt      <= '0;
      buf_q    <= '0;
      buf_v    <= 1'b0;
      last     <= ID_LAST;
      LD_seed  <= 1'b0;
      ready    <= 1'b0;
      zero_err <= 1'b0;
      gnt      <= '0;
      gnt_id   <= '0;
      gnt_data <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      LD_seed <= (state_nxt == SEED);
      ready   <= (state_nxt == RUN);

      if (state == RUN && rand_valid && !rand_nz) zero_err <= 1'b1;

      gnt      <= '0;
      gnt_id   <= '0;
      gnt_data <= '0;
      if (grant_now) begin
        gnt      <= NUM_REQ'(1) << win_idx;
        gnt_id   <= win_idx;
        gnt_data <= buf_q;
        last     <= win_idx;
      end

      if (seed_req || state != RUN) begin
        buf_v <= 1'b0;
      end else if (refill) begin
        buf_q <= rand_value;
        buf_v <= 1'b1;
      end else if (grant_now) begin
        buf_v <= 1'b0;
      end
    end
  end

`ifdef RAND_GRANT_CNT_EN
  always_ff @(posedge setup_clk or posedge RESET_SIM) begin
    if (RESET_SIM) begin
      grant_cnt <= '0;
    end else if (seed_req) begin
      grant_cnt <= '0;
    end else if (grant_now && grant_cnt[win_idx] != 16'hFFFF) begin
      grant_cnt[win_idx] <= grant_cnt[win_idx] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_setup_rand_arbiter.sv
// -----------------------------------------------------------------------------
// tb_setup_rand_arbiter
//
// Bench for setup_rand_arbiter. The flow is:
//   1. Reset.
//   2. A directed vector table that covers seeding, first-word discard,
//      round-robin order, drop-when-full, zero words and reseed mid-grant.
//   3. Randomized traffic. This includes random reseeds and one mid-run
//      reset.
//
// A reference model built from plain integers and a one-entry word queue
// predicts every output in every cycle.
// -----------------------------------------------------------------------------
module tb_setup_rand_arbiter;
  localparam int NUM_REQ     = 3;
  localparam int REQ_bits    = 2;
  localparam int DATA_W      = 32;
  localparam int SEED_CYCLES = 4;

  // ---------------- clock / reset / DUT ----------------
  logic                 setup_clk = 1'b0;
  logic                 RESET_SIM = 1'b1;
  logic                 seed_req = 1'b0;
  logic                 rand_valid = 1'b0;
  logic [DATA_W-1:0]    rand_value = '0;
  logic [NUM_REQ-1:0]   req = '0;
  logic                 LD_seed, ready, zero_err;
  logic [NUM_REQ-1:0]   gnt;
  logic [DATA_W-1:0]    gnt_data;
  logic [REQ_bits-1:0]  gnt_id;
  logic [1:0]           state_dbg;
`ifdef RAND_GRANT_CNT_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt;
`endif

  always #5 setup_clk = ~setup_clk;

  setup_rand_arbiter #(
    .NUM_REQ(NUM_REQ), .REQ_bits(REQ_bits), .DATA_W(DATA_W), .SEED_CYCLES(SEED_CYCLES)
  ) dut (
    .setup_clk(setup_clk),
    .RESET_SIM(RESET_SIM),
    .seed_req(seed_req),
    .LD_seed(LD_seed),
    .rand_value(rand_value),
    .rand_valid(rand_valid),
    .req(req),
    .gnt(gnt),
    .gnt_data(gnt_data),
    .gnt_id(gnt_id),
    .ready(ready),
    .zero_err(zero_err),
`ifdef RAND_GRANT_CNT_EN
    .grant_cnt(grant_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 seeding, 2 waiting for nonzero word, 3 running
  int                m_phase, m_seed_done, m_last, m_prev;
  logic [31:0]       exp_q[$];   // the buffered word (at most one entry)
  logic              m_zero;
  logic              e_ld, e_rdy;
  logic [2:0]        e_gnt;
  logic [1:0]        e_id;
  logic [31:0]       e_data;
  int                m_cnt[NUM_REQ];

  task automatic model_reset();
    m_phase = 0; m_seed_done = 0; m_last = NUM_REQ - 1; m_prev = -1;
    exp_q.delete(); m_zero = 1'b0;
    e_ld = 1'b0; e_rdy = 1'b0; e_gnt = '0; e_id = '0; e_data = '0;
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step(input logic s, input logic v, input logic [31:0] d,
                            input logic [2:0] r);
    int win;
    int idx;
    logic [31:0] w;
    win = -1;
    w   = '0;
    if (m_phase == 3 && !s && exp_q.size() > 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (m_last + k) % NUM_REQ;
        if (win < 0 && r[idx] && idx != m_prev) win = idx;
      end
    end
    if (m_phase == 3 && v && d == 0) m_zero = 1'b1;
    if (win >= 0) w = exp_q.pop_front();
    if (s || m_phase != 3) exp_q.delete();
    else if (v && d != 0 && exp_q.size() == 0) exp_q.push_back(d);

    if (s) begin
      for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    end else if (win >= 0 && m_cnt[win] < 65535) begin
      m_cnt[win]++;
    end

    if (s) begin
      m_phase = 1; m_seed_done = 0;
    end else if (m_phase == 1) begin
      m_seed_done++;
      if (m_seed_done == SEED_CYCLES) m_phase = 2;
    end else if (m_phase == 2 && v && d != 0) begin
      m_phase = 3;
    end

    e_ld   = (m_phase == 1);
    e_rdy  = (m_phase == 3);
    e_gnt  = (win >= 0) ? 3'(1 << win) : 3'b000;
    e_id   = (win >= 0) ? 2'(win) : 2'b00;
    e_data = w;
    if (win >= 0) m_last = win;
    m_prev = win;
  endtask

  // ---------------- driver ----------------
  // This task is called at a negedge. It drives the inputs, lets one posedge
  // pass, then checks the registered outputs at the following negedge.
  task automatic step(input logic s, input logic v, input logic [31:0] d, input logic [2:0] r);
    seed_req = s; rand_valid = v; rand_value = d; req = r;
    model_step(s, v, d, r);
    @(posedge setup_clk);
    @(negedge setup_clk);
    check("LD_seed",  32'(LD_seed),  32'(e_ld));
    check("ready",    32'(ready),    32'(e_rdy));
    check("gnt",      32'(gnt),      32'(e_gnt));
    check("gnt_id",   32'(gnt_id),   32'(e_id));
    check("gnt_data", gnt_data,      e_data);
    check("zero_err", 32'(zero_err), 32'(m_zero));
`ifdef RAND_GRANT_CNT_EN
    for (int i = 0; i < NUM_REQ; i++) check("grant_cnt", 32'(grant_cnt[i]), 32'(m_cnt[i]));
`endif
  endtask

  task automatic do_reset();
    seed_req = 1'b0; rand_valid = 1'b0; rand_value = '0; req = '0;
    RESET_SIM = 1'b1;
    #2;
    model_reset();
    check("rst_LD_seed",  32'(LD_seed),  32'd0);
    check("rst_ready",    32'(ready),    32'd0);
    check("rst_gnt",      32'(gnt),      32'd0);
    check("rst_gnt_id",   32'(gnt_id),   32'd0);
    check("rst_gnt_data", gnt_data,      32'd0);
    check("rst_zero_err", 32'(zero_err), 32'd0);
    @(negedge setup_clk);
    @(negedge setup_clk);
    RESET_SIM = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic s; logic v; logic [31:0] d; logic [2:0] r;
    logic ld; logic rdy; logic [2:0] g; logic [1:0] id; logic [31:0] data; logic z;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic s, input logic v, input logic [31:0] d,
                              input logic [2:0] r, input logic ld, input logic rdy,
                              input logic [2:0] g, input logic [1:0] id,
                              input logic [31:0] data, input logic z);
    vec_t t;
    t.s = s; t.v = v; t.d = d; t.r = r;
    t.ld = ld; t.rdy = rdy; t.g = g; t.id = id; t.data = data; t.z = z;
    return t;
  endfunction

  initial begin
    int          age[NUM_REQ];
    logic [2:0]  rq;
    logic        s, v;
    logic [31:0] d;

    //               s  v  data            req     ld rdy gnt     id  gnt_data        zero
    tbl[0]  = mk(1, 0, 32'h0,          3'b000, 1, 0, 3'b000, 0, 32'h0,          0);
    tbl[1]  = mk(0, 0, 32'h0,          3'b000, 1, 0, 3'b000, 0, 32'h0,          0);
    tbl[2]  = mk(0, 0, 32'h0,          3'b000, 1, 0, 3'b000, 0, 32'h0,          0);
    tbl[3]  = mk(0, 0, 32'h0,          3'b000, 1, 0, 3'b000, 0, 32'h0,          0);
    tbl[4]  = mk(0, 0, 32'h0,          3'b000, 0, 0, 3'b000, 0, 32'h0,          0);
    tbl[5]  = mk(0, 1, 32'h0,          3'b000, 0, 0, 3'b000, 0, 32'h0,          0);
    tbl[6]  = mk(0, 1, 32'h1234_5678,  3'b000, 0, 1, 3'b000, 0, 32'h0,          0);
    tbl[7]  = mk(0, 1, 32'h1,          3'b111, 0, 1, 3'b000, 0, 32'h0,          0);
    tbl[8]  = mk(0, 1, 32'h2,          3'b111, 0, 1, 3'b001, 0, 32'h1,          0);
    tbl[9]  = mk(0, 1, 32'h3,          3'b111, 0, 1, 3'b010, 1, 32'h2,          0);
    tbl[10] = mk(0, 1, 32'h4,          3'b111, 0, 1, 3'b100, 2, 32'h3,          0);
    tbl[11] = mk(0, 1, 32'h5,          3'b111, 0, 1, 3'b001, 0, 32'h4,          0);
    tbl[12] = mk(0, 0, 32'h0,          3'b010, 0, 1, 3'b010, 1, 32'h5,          0);
    tbl[13] = mk(0, 1, 32'hAAAA_0001,  3'b000, 0, 1, 3'b000, 0, 32'h0,          0);
    tbl[14] = mk(0, 1, 32'hBBBB_0002,  3'b000, 0, 1, 3'b000, 0, 32'h0,          0);
    tbl[15] = mk(0, 0, 32'h0,          3'b010, 0, 1, 3'b010, 1, 32'hAAAA_0001,  0);
    tbl[16] = mk(0, 1, 32'h0,          3'b000, 0, 1, 3'b000, 0, 32'h0,          1);
    tbl[17] = mk(0, 1, 32'h77,         3'b000, 0, 1, 3'b000, 0, 32'h0,          1);
    tbl[18] = mk(0, 1, 32'h0,          3'b000, 0, 1, 3'b000, 0, 32'h0,          1);
    tbl[19] = mk(0, 0, 32'h0,          3'b100, 0, 1, 3'b100, 2, 32'h77,         1);
    tbl[20] = mk(0, 1, 32'h88,         3'b001, 0, 1, 3'b000, 0, 32'h0,          1);
    tbl[21] = mk(1, 0, 32'h0,          3'b001, 1, 0, 3'b000, 0, 32'h0,          1);
    tbl[22] = mk(0, 0, 32'h0,          3'b001, 1, 0, 3'b000, 0, 32'h0,          1);
    tbl[23] = mk(0, 0, 32'h0,          3'b001, 1, 0, 3'b000, 0, 32'h0,          1);
    tbl[24] = mk(0, 0, 32'h0,          3'b001, 1, 0, 3'b000, 0, 32'h0,          1);
    tbl[25] = mk(0, 0, 32'h0,          3'b001, 0, 0, 3'b000, 0, 32'h0,          1);
    tbl[26] = mk(0, 1, 32'h9,          3'b001, 0, 1, 3'b000, 0, 32'h0,          1);
    tbl[27] = mk(0, 1, 32'hA,          3'b001, 0, 1, 3'b000, 0, 32'h0,          1);
    tbl[28] = mk(0, 0, 32'h0,          3'b001, 0, 1, 3'b001, 0, 32'hA,          1);

    @(negedge setup_clk);
    do_reset();

    for (int n = 0; n < NV; n++) begin
      step(tbl[n].s, tbl[n].v, tbl[n].d, tbl[n].r);
      check("tbl_LD_seed",  32'(LD_seed),  32'(tbl[n].ld));
      check("tbl_ready",    32'(ready),    32'(tbl[n].rdy));
      check("tbl_gnt",      32'(gnt),      32'(tbl[n].g));
      check("tbl_gnt_id",   32'(gnt_id),   32'(tbl[n].id));
      check("tbl_gnt_data", gnt_data,      tbl[n].data);
      check("tbl_zero_err", 32'(zero_err), 32'(tbl[n].z));
    end

    // ---------------- randomized traffic ----------------
    rq = '0;
    for (int i = 0; i < NUM_REQ; i++) age[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        // Reset in the middle of traffic, then seed again.
        do_reset();
        rq = '0;
        for (int i = 0; i < NUM_REQ; i++) age[i] = 0;
        step(1'b1, 1'b0, 32'h0, 3'b000);
      end
      // Requester behaviour: hold req through the gnt cycle, drop it the
      // cycle after, then re-request at random later.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (age[i] == 1) begin
          age[i] = 2;
        end else if (age[i] == 2) begin
          rq[i]  = 1'b0;
          age[i] = 0;
        end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
          rq[i] = 1'b1;
        end
      end
      s = ($urandom_range(0, 399) == 0);
      v = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      step(s, v, d, rq);
      for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) age[i] = 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
